uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver. Pairs with the existing transmitter: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity.
- Sits between the board RX pin and the host byte sink.
- Synchronises the asynchronous line, validates the start bit, samples each bit mid-cell, and emits a one-cycle data-valid pulse per good byte.
- Reports stop-bit framing errors separately.

Parameters:
- CLKS_PER_BIT, 87, i_Clock cycles per bit (clock freq / baud). Legal range 8..65535.
- HALF_BIT (localparam), (CLKS_PER_BIT-1)/2 with integer truncation, start-bit sample offset.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Serial  input  1  asynchronous serial line, idle high
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received good byte
- o_Rx_Byte  output  8  last good received byte; held between frames
- o_Rx_Active  output  1  high while a frame is being received
- o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Clocking and reset: one clock, i_Clock. i_Reset is asynchronous and active-high.
- Reset values:
  - o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Frame_Err=0.
  - State=s_IDLE, bit index=0, clock counter=0.
  - Both synchroniser flops=1, so release from reset never fakes a start bit.
- Input path: 2-flop synchroniser on i_Rx_Serial; only the second flop (rx_s) feeds the FSM.
- Clock counter: 16-bit, never wraps. Counts 0..CLKS_PER_BIT-1 within a bit cell.
- State s_IDLE:
  - Counter=0, index=0.
  - If rx_s==0: go to s_START, o_Rx_Active<=1.
- State s_START:
  - Count up to HALF_BIT, then sample.
  - Sample 0: counter<=0, go to s_DATA.
  - Sample 1: false start; go to s_IDLE, o_Rx_Active<=0, no output pulses.
- State s_DATA:
  - When counter==CLKS_PER_BIT-1: shift register bit[index]<=sample, counter<=0.
  - index<7: index++.
  - index==7: go to s_STOP.
- State s_STOP, sample at counter==CLKS_PER_BIT-1:
  - Sample 1: o_Rx_Byte<=shift register, o_Rx_DV<=1, go to s_CLEANUP.
  - Sample 0: o_Rx_Frame_Err<=1, o_Rx_Byte unchanged, go to s_WAIT_IDLE.
- State s_CLEANUP: one cycle. Clears the DV pulse, o_Rx_Active<=0, go to s_IDLE.
- State s_WAIT_IDLE:
  - Clears the error pulse.
  - Stays until rx_s==1, then o_Rx_Active<=0 and go to s_IDLE. A held-low line (break) must not retrigger frames.
- Latency: let t0 be the rising edge at which the synchroniser first captures a low.
  - Start sample at edge t0+3+HALF_BIT.
  - Data bit k (0..7) sampled at edge t0+3+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop sampled at edge t0+3+HALF_BIT+9*CLKS_PER_BIT; o_Rx_DV is high for exactly the following cycle.
  - For CLKS_PER_BIT=87: DV goes high after edge t0+829.
- Back-to-back frames: s_CLEANUP returns to s_IDLE about half a bit before the stop cell ends. A start edge immediately after the stop cell is caught with no lost byte.
- Exclusivity: o_Rx_DV and o_Rx_Frame_Err are never high together.
- Reset mid-frame: asynchronous return to the reset values. A partially assembled byte is discarded; no pulses are emitted.
- Undefined states decode to s_IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-bit history of rx_s is kept.
  - Every sample point (start, data, stop) uses the 2-of-3 majority of rx_s at counter values point-2, point-1 and point.
  - IDLE start detection remains single-sample.
  - Latency is identical.
- Undefined: single sample of rx_s at the sample point; no history register.

Test Plan:
- Good byte: CLKS_PER_BIT=87, send 0xA5 with stop=1 -> o_Rx_DV high for exactly 1 cycle after edge t0+829; o_Rx_Byte=0xA5; o_Rx_Frame_Err stays 0; o_Rx_Active falls 1 cycle after DV.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two DV pulses 870 cycles apart; bytes 0x00 then 0xFF.
- False start: 20-cycle low glitch -> o_Rx_Active rises then falls; no DV, no error; o_Rx_Byte unchanged. A following 0x3C is received correctly.
- Framing error: prior byte 0x12, then send 0x55 with stop=0 and line held low 3 further bit times -> one-cycle Frame_Err; no DV; o_Rx_Byte stays 0x12; Active stays high until the line returns high; next frame 0x81 is received OK.
- Reset mid-frame: assert i_Reset during data bit 4 -> all outputs 0 immediately. After release, frame 0xC3 is received with correct DV timing.
- Majority: single-cycle high glitch on a 0 data bit exactly at its sample point -> with UART_RX_MAJORITY_EN the bit is read 0; without the macro the bit is read 1.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with a 2-flop input synchroniser and stop-bit framing-error reporting.
// Defining UART_RX_MAJORITY_EN makes every sample point a 2-of-3 vote over the last three rx_s values.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_STOP,
    s_CLEANUP,
    s_WAIT_IDLE
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        meta_q;
  logic        rx_s_q;
  logic        sample_bit;

  // Both flops reset high so leaving reset never looks like a start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= i_Rx_Serial;
      rx_s_q <= meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample_bit = rx_s_q;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q        <= s_IDLE;
      cnt_q          <= 16'd0;
      idx_q          <= 3'd0;
      shift_q        <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (state_q)
        s_IDLE: begin
          cnt_q <= 16'd0;
          idx_q <= 3'd0;
          if (!rx_s_q) begin
            state_q     <= s_START;
            o_Rx_Active <= 1'b1;
          end
        end

        // Mid start-bit check rejects glitches shorter than half a bit.
        s_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q <= 16'd0;
            if (!sample_bit) begin
              state_q <= s_DATA;
            end else begin
              state_q     <= s_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        s_DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q          <= 16'd0;
            shift_q[idx_q] <= sample_bit;
            if (idx_q == 3'd7) begin
              state_q <= s_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        s_STOP: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= 16'd0;
            if (sample_bit) begin
              o_Rx_Byte <= shift_q;
              o_Rx_DV   <= 1'b1;
              state_q   <= s_CLEANUP;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
              state_q        <= s_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        s_CLEANUP: begin
          o_Rx_Active <= 1'b0;
          state_q     <= s_IDLE;
        end

        // A held-low line (break) parks here instead of starting new frames.
        s_WAIT_IDLE: begin
          if (rx_s_q) begin
            o_Rx_Active <= 1'b0;
            state_q     <= s_IDLE;
          end
        end

        default: begin
          state_q <= s_IDLE;
        end
      endcase
    end
  end

endmodule
